// File: rtl/dly_value_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dly_value_ctrl
// Desc   : Owns twenty 6-bit delay tap registers and updates one per addressed
//          command (load/inc/dec/restore), then holds off for a settle window.
// Rev    : 1.0  initial release
// ============================================================================
module dly_value_ctrl #(
    parameter int         SETTLE_CYCLES = 3,
    parameter logic [5:0] INIT_TAP      = 6'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [5:0] cmd_data,
    input  logic [4:0] dly_addr,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic       cmd_sat,
    output logic [5:0] dly_tap0_val,
    output logic [5:0] dly_tap1_val,
    output logic [5:0] dly_tap2_val,
    output logic [5:0] dly_tap3_val,
    output logic [5:0] dly_tap4_val,
    output logic [5:0] dly_tap5_val,
    output logic [5:0] dly_tap6_val,
    output logic [5:0] dly_tap7_val,
    output logic [5:0] dly_tap8_val,
    output logic [5:0] dly_tap9_val,
    output logic [5:0] dly_tap10_val,
    output logic [5:0] dly_tap11_val,
    output logic [5:0] dly_tap12_val,
    output logic [5:0] dly_tap13_val,
    output logic [5:0] dly_tap14_val,
    output logic [5:0] dly_tap15_val,
    output logic [5:0] dly_tap16_val,
    output logic [5:0] dly_tap17_val,
    output logic [5:0] dly_tap18_val,
    output logic [5:0] dly_tap19_val
);

    localparam int         c_num_taps    = 20;
    localparam logic [1:0] c_op_load     = 2'b00;
    localparam logic [1:0] c_op_inc      = 2'b01;
    localparam logic [1:0] c_op_dec      = 2'b10;
    localparam logic [5:0] c_tap_max     = 6'd63;
    localparam logic [3:0] c_settle_load = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_apply    = 2'd1;
    localparam logic [1:0] c_st_settle   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_op;
    logic [5:0] r_data;
    logic [4:0] r_addr;
    logic [3:0] r_cnt;
    logic [5:0] r_tap [c_num_taps];
    logic       r_done;
    logic       r_err;
    logic       r_sat;
    logic       w_to_idle;
    logic       w_addr_bad;
    logic       w_sat;
    logic       w_we;
    logic [5:0] w_cur;
    logic [5:0] w_new;

    assign w_addr_bad = (r_addr >= 5'd20);
    assign w_we       = (r_state == c_st_apply) && !w_addr_bad;

    always_comb begin
        w_cur = INIT_TAP;
        for (int i = 0; i < c_num_taps; i++) begin
            if (r_addr == 5'(i)) w_cur = r_tap[i];
        end
    end

    // Saturation leaves the tap untouched; a bad address reports ERR only.
    always_comb begin
        w_new = w_cur;
        w_sat = 1'b0;
        case (r_op)
            c_op_load: w_new = r_data;
            c_op_inc: begin
                if (w_cur == c_tap_max) w_sat = 1'b1;
                else                    w_new = w_cur + 6'd1;
            end
            c_op_dec: begin
                if (w_cur == 6'd0) w_sat = 1'b1;
                else               w_new = w_cur - 6'd1;
            end
            default: w_new = INIT_TAP;
        endcase
        if (w_addr_bad) w_sat = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_to_idle   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (cmd_valid) w_state_nxt = c_st_apply;
            end
            c_st_apply: begin
                if (SETTLE_CYCLES > 0) begin
                    w_state_nxt = c_st_settle;
                end else begin
                    w_state_nxt = c_st_idle;
                    w_to_idle   = 1'b1;
                end
            end
            c_st_settle: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_idle;
                    w_to_idle   = 1'b1;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_op    <= 2'b00;
            r_data  <= 6'd0;
            r_addr  <= 5'd0;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_to_idle;
            if ((r_state == c_st_idle) && cmd_valid) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
                r_addr <= dly_addr;
            end
            if (r_state == c_st_apply) begin
                r_err <= w_addr_bad;
                r_sat <= w_sat;
                r_cnt <= c_settle_load;
            end else if ((r_state == c_st_settle) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_num_taps; i++) r_tap[i] <= INIT_TAP;
        end else if (w_we) begin
            for (int i = 0; i < c_num_taps; i++) begin
                if (r_addr == 5'(i)) r_tap[i] <= w_new;
            end
        end
    end

    assign cmd_ready = (r_state == c_st_idle);
    assign cmd_done  = r_done;
    assign cmd_err   = r_done & r_err;
    assign cmd_sat   = r_done & r_sat;

    assign dly_tap0_val  = r_tap[0];
    assign dly_tap1_val  = r_tap[1];
    assign dly_tap2_val  = r_tap[2];
    assign dly_tap3_val  = r_tap[3];
    assign dly_tap4_val  = r_tap[4];
    assign dly_tap5_val  = r_tap[5];
    assign dly_tap6_val  = r_tap[6];
    assign dly_tap7_val  = r_tap[7];
    assign dly_tap8_val  = r_tap[8];
    assign dly_tap9_val  = r_tap[9];
    assign dly_tap10_val = r_tap[10];
    assign dly_tap11_val = r_tap[11];
    assign dly_tap12_val = r_tap[12];
    assign dly_tap13_val = r_tap[13];
    assign dly_tap14_val = r_tap[14];
    assign dly_tap15_val = r_tap[15];
    assign dly_tap16_val = r_tap[16];
    assign dly_tap17_val = r_tap[17];
    assign dly_tap18_val = r_tap[18];
    assign dly_tap19_val = r_tap[19];

endmodule
`default_nettype wire

// File: tb/tb_dly_value_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dly_value_ctrl
// Desc   : Two controller instances (settle 3 / init 10, settle 0 / init 20)
//          checked every cycle against a command-level model plus literals.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dly_value_ctrl;

    localparam logic [1:0] c_load    = 2'b00;
    localparam logic [1:0] c_inc     = 2'b01;
    localparam logic [1:0] c_dec     = 2'b10;
    localparam logic [1:0] c_restore = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       valid [2];
    logic [1:0] op    [2];
    logic [5:0] data  [2];
    logic [4:0] addr  [2];
    logic       ready [2];
    logic       done  [2];
    logic       err   [2];
    logic       sat   [2];
    logic [5:0] tap   [2][20];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;

    function automatic int settle_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    function automatic int init_of(input int k);
        return (k == 0) ? 10 : 20;
    endfunction

    dly_value_ctrl #(.SETTLE_CYCLES(3), .INIT_TAP(6'd10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
        .cmd_op(op[0]), .cmd_data(data[0]), .dly_addr(addr[0]),
        .cmd_done(done[0]), .cmd_err(err[0]), .cmd_sat(sat[0]),
        .dly_tap0_val(tap[0][0]),   .dly_tap1_val(tap[0][1]),   .dly_tap2_val(tap[0][2]),
        .dly_tap3_val(tap[0][3]),   .dly_tap4_val(tap[0][4]),   .dly_tap5_val(tap[0][5]),
        .dly_tap6_val(tap[0][6]),   .dly_tap7_val(tap[0][7]),   .dly_tap8_val(tap[0][8]),
        .dly_tap9_val(tap[0][9]),   .dly_tap10_val(tap[0][10]), .dly_tap11_val(tap[0][11]),
        .dly_tap12_val(tap[0][12]), .dly_tap13_val(tap[0][13]), .dly_tap14_val(tap[0][14]),
        .dly_tap15_val(tap[0][15]), .dly_tap16_val(tap[0][16]), .dly_tap17_val(tap[0][17]),
        .dly_tap18_val(tap[0][18]), .dly_tap19_val(tap[0][19])
    );

    dly_value_ctrl #(.SETTLE_CYCLES(0), .INIT_TAP(6'd20)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
        .cmd_op(op[1]), .cmd_data(data[1]), .dly_addr(addr[1]),
        .cmd_done(done[1]), .cmd_err(err[1]), .cmd_sat(sat[1]),
        .dly_tap0_val(tap[1][0]),   .dly_tap1_val(tap[1][1]),   .dly_tap2_val(tap[1][2]),
        .dly_tap3_val(tap[1][3]),   .dly_tap4_val(tap[1][4]),   .dly_tap5_val(tap[1][5]),
        .dly_tap6_val(tap[1][6]),   .dly_tap7_val(tap[1][7]),   .dly_tap8_val(tap[1][8]),
        .dly_tap9_val(tap[1][9]),   .dly_tap10_val(tap[1][10]), .dly_tap11_val(tap[1][11]),
        .dly_tap12_val(tap[1][12]), .dly_tap13_val(tap[1][13]), .dly_tap14_val(tap[1][14]),
        .dly_tap15_val(tap[1][15]), .dly_tap16_val(tap[1][16]), .dly_tap17_val(tap[1][17]),
        .dly_tap18_val(tap[1][18]), .dly_tap19_val(tap[1][19])
    );

    initial begin
        clk = 1'b0;
        #10;
        forever #5 clk = ~clk;
    end

    // Command-level model: a command occupies the block for N+1 edges after
    // acceptance, the tap changes on the first of them, DONE follows the last.
    int         m_busy  [2];
    logic       m_first [2];
    logic       m_done  [2];
    logic       m_err   [2];
    logic       m_sat   [2];
    logic [1:0] m_op    [2];
    logic [4:0] m_addr  [2];
    int         m_data  [2];
    int         m_tap   [2][20];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n) cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    m_busy[k]  = 0;
                    m_first[k] = 1'b0;
                    m_done[k]  = 1'b0;
                    m_err[k]   = 1'b0;
                    m_sat[k]   = 1'b0;
                    for (int j = 0; j < 20; j++) m_tap[k][j] = init_of(k);
                end else begin
                    m_done[k] = 1'b0;
                    if (m_busy[k] == 0) begin
                        if (valid[k]) begin
                            m_op[k]    = op[k];
                            m_addr[k]  = addr[k];
                            m_data[k]  = int'(data[k]);
                            m_busy[k]  = settle_of(k) + 1;
                            m_first[k] = 1'b1;
                        end
                    end else begin
                        if (m_first[k]) begin
                            m_first[k] = 1'b0;
                            m_err[k]   = (m_addr[k] > 5'd19);
                            m_sat[k]   = 1'b0;
                            if (!m_err[k]) begin
                                case (m_op[k])
                                    c_load: m_tap[k][m_addr[k]] = m_data[k];
                                    c_inc:
                                        if (m_tap[k][m_addr[k]] == 63) m_sat[k] = 1'b1;
                                        else m_tap[k][m_addr[k]] = m_tap[k][m_addr[k]] + 1;
                                    c_dec:
                                        if (m_tap[k][m_addr[k]] == 0) m_sat[k] = 1'b1;
                                        else m_tap[k][m_addr[k]] = m_tap[k][m_addr[k]] - 1;
                                    default: m_tap[k][m_addr[k]] = init_of(k);
                                endcase
                            end
                        end
                        m_busy[k] = m_busy[k] - 1;
                        if (m_busy[k] == 0) m_done[k] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0]   act_ctl;
        logic [3:0]   exp_ctl;
        logic [119:0] act_taps;
        logic [119:0] exp_taps;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    act_ctl = {ready[k], done[k], err[k], sat[k]};
                    exp_ctl = {(m_busy[k] == 0), m_done[k], m_done[k] & m_err[k], m_done[k] & m_sat[k]};
                    checks++;
                    if (act_ctl !== exp_ctl) begin
                        failures++;
                        $display("FAIL ctl[%0d] t=%0t actual rdy/done/err/sat=%b required=%b", k, $time, act_ctl, exp_ctl);
                    end
                    for (int j = 0; j < 20; j++) begin
                        act_taps[j*6 +: 6] = tap[k][j];
                        exp_taps[j*6 +: 6] = 6'(m_tap[k][j]);
                    end
                    checks++;
                    if (act_taps !== exp_taps) begin
                        failures++;
                        $display("FAIL taps[%0d] t=%0t actual=%h required=%h", k, $time, act_taps, exp_taps);
                    end
                end
            end
        end
    end

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic do_cmd(input int k, input logic [1:0] o, input logic [4:0] a,
                          input logic [5:0] d, output int lat, output logic e, output logic s);
        int n;
        @(negedge clk);
        valid[k] = 1'b1;
        op[k]    = o;
        addr[k]  = a;
        data[k]  = d;
        n = 0;
        while (!ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        valid[k] = 1'b0;
        lat = 0;
        while (!done[k] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        e = err[k];
        s = sat[k];
    endtask

    task automatic cmd_chk(input string nm, input int k, input logic [1:0] o, input logic [4:0] a,
                           input logic [5:0] d, input int xe, input int xs);
        int   lat;
        logic e;
        logic s;
        do_cmd(k, o, a, d, lat, e, s);
        lit({nm, "_lat"}, lat, settle_of(k) + 1);
        lit({nm, "_err"}, int'(e), xe);
        lit({nm, "_sat"}, int'(s), xs);
    endtask

    initial begin
        int acc;
        int dn;
        int prev;
        int n;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0;
            op[k]    = 2'b00;
            data[k]  = 6'd0;
            addr[k]  = 5'd0;
        end

        // Reset with the clock still stopped.
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 20; j++) lit($sformatf("rst_tap%0d_%0d", k, j), int'(tap[k][j]), init_of(k));
            lit($sformatf("rst_ready%0d", k), int'(ready[k]), 1);
            lit($sformatf("rst_done%0d", k), int'(done[k]), 0);
        end
        #20 rst_n = 1'b1;
        chk_en = 1'b1;

        // LOAD tap 7 = 45, settle 3: tap after E1, DONE after E4, accept at E5.
        @(negedge clk);
        valid[0] = 1'b1; op[0] = c_load; addr[0] = 5'd7; data[0] = 6'd45;
        @(negedge clk);
        valid[0] = 1'b0;
        lit("load_ready_e0", int'(ready[0]), 0);
        lit("load_tap_e0", int'(tap[0][7]), 10);
        @(negedge clk);
        lit("load_tap_e1", int'(tap[0][7]), 45);
        lit("load_tap6_e1", int'(tap[0][6]), 10);
        @(negedge clk);
        @(negedge clk);
        lit("load_done_e3", int'(done[0]), 0);
        @(negedge clk);
        lit("load_done_e4", int'(done[0]), 1);
        lit("load_ready_e4", int'(ready[0]), 1);
        valid[0] = 1'b1; op[0] = c_inc; addr[0] = 5'd7;
        @(negedge clk);
        valid[0] = 1'b0;
        lit("next_accept_e5", int'(ready[0]), 0);
        n = 0;
        while (!done[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        lit("inc7_lat", n, 4);
        lit("inc7_tap", int'(tap[0][7]), 46);

        // Saturation and bad addresses on the settle-3 instance.
        cmd_chk("load0_63", 0, c_load, 5'd0, 6'd63, 0, 0);
        cmd_chk("inc0_sat", 0, c_inc, 5'd0, 6'd0, 0, 1);
        lit("inc0_sat_tap", int'(tap[0][0]), 63);
        cmd_chk("load19_0", 0, c_load, 5'd19, 6'd0, 0, 0);
        cmd_chk("dec19_sat", 0, c_dec, 5'd19, 6'd0, 0, 1);
        lit("dec19_sat_tap", int'(tap[0][19]), 0);
        cmd_chk("load19_1", 0, c_load, 5'd19, 6'd1, 0, 0);
        cmd_chk("dec19_nosat", 0, c_dec, 5'd19, 6'd0, 0, 0);
        lit("dec19_tap", int'(tap[0][19]), 0);
        cmd_chk("bad20", 0, c_load, 5'd20, 6'd12, 1, 0);
        cmd_chk("bad31", 0, c_load, 5'd31, 6'd12, 1, 0);
        lit("bad_tap12", int'(tap[0][12]), 10);
        cmd_chk("inc4", 0, c_inc, 5'd4, 6'd0, 0, 0);
        lit("inc4_tap", int'(tap[0][4]), 11);
        cmd_chk("dec6", 0, c_dec, 5'd6, 6'd0, 0, 0);
        lit("dec6_tap", int'(tap[0][6]), 9);

        // Back-to-back INC on the settle-0 instance with valid held high.
        @(negedge clk);
        valid[1] = 1'b1; op[1] = c_inc; addr[1] = 5'd3; data[1] = 6'd0;
        acc = 0; dn = 0; prev = 0; n = 0;
        while (acc < 5 && n < 60) begin
            if (done[1]) dn++;
            if (ready[1]) begin
                acc++;
                if (acc > 1) lit("b2b_gap", cyc - prev, 2);
                prev = cyc;
            end
            @(negedge clk);
            n++;
        end
        valid[1] = 1'b0;
        n = 0;
        while (!done[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (done[1]) dn++;
        lit("b2b_accepts", acc, 5);
        lit("b2b_dones", dn, 5);
        lit("b2b_tap3", int'(tap[1][3]), 25);

        // Reset during SETTLE after LOAD tap 5 = 30.
        @(negedge clk);
        valid[0] = 1'b1; op[0] = c_load; addr[0] = 5'd5; data[0] = 6'd30;
        @(negedge clk);
        valid[0] = 1'b0;
        @(negedge clk);
        lit("mid_tap5_loaded", int'(tap[0][5]), 30);
        #2 rst_n = 1'b0;
        #1;
        lit("mid_tap5_reset", int'(tap[0][5]), 10);
        lit("mid_ready_reset", int'(ready[0]), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done[0]) dn++;
        end
        lit("mid_no_done", dn, 0);
        lit("mid_ready_after", int'(ready[0]), 1);
        cmd_chk("reload5", 0, c_load, 5'd5, 6'd33, 0, 0);
        lit("reload5_tap", int'(tap[0][5]), 33);
        cmd_chk("restore5", 0, c_restore, 5'd5, 6'd0, 0, 0);
        lit("restore5_tap", int'(tap[0][5]), 10);
        cmd_chk("restore_b", 1, c_restore, 5'd3, 6'd0, 0, 0);
        lit("restore_b_tap", int'(tap[1][3]), 20);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
